layer_engine_arbiter: RTL and testbench

Shares one matrix-vector layer engine (M outputs of N inputs, T-bit words, valid/ready on both sides) between two independent requesters. It grants the engine's input port to one requester for a whole N-word input vector, in round-robin order. It records the grant order in a small tag FIFO and uses it to route each M-word result burst back to the requester that owns it. It sits between two upstream producers and the layer engine, in the same clock domain.

---
 rtl/layer_engine_arbiter.sv | 138 +++++++++++++
 tb/tb_layer_engine_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_engine_arbiter.sv
// rtl/layer_engine_arbiter.sv - round-robin sharing of one layer engine between two requesters
// Grants whole input vectors; a tag FIFO of grant order routes each result burst back.
module layer_engine_arbiter #(
  parameter int M     = 8,
  parameter int N     = 8,
  parameter int T     = 12,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         s_valid0,
  output logic         s_ready0,
  input  logic [T-1:0] data_in0,
  input  logic         s_valid1,
  output logic         s_ready1,
  input  logic [T-1:0] data_in1,
  output logic         m_valid0,
  input  logic         m_ready0,
  output logic         m_valid1,
  input  logic         m_ready1,
  output logic [T-1:0] data_out,
  output logic         e_s_valid,
  input  logic         e_s_ready,
  output logic [T-1:0] e_data_in,
  input  logic         e_m_valid,
  output logic         e_m_ready,
  input  logic [T-1:0] e_data_out,
  output logic         busy
);

  localparam int ICW = $clog2(N + 1);
  localparam int OCW = $clog2(M + 1);
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH + 1);

  typedef enum logic {IDLE, PASS} state_t;

  state_t         state;
  logic           grant;
  logic           last_grant;
  logic [ICW-1:0] in_cnt;
  logic [OCW-1:0] out_cnt;
  logic [DEPTH-1:0] tag_mem;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;

  logic fifo_ne;
  logic head;
  logic in_fire;
  logic out_fire;
  logic push;
  logic pop;
  logic req_any;
  logic next_grant;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Input side: only the granted requester sees the engine's ready.
  assign e_s_valid = (state == PASS) & (grant ? s_valid1 : s_valid0);
  assign e_data_in = grant ? data_in1 : data_in0;
  assign s_ready0  = (state == PASS) & ~grant & e_s_ready;
  assign s_ready1  = (state == PASS) &  grant & e_s_ready;
  assign in_fire   = e_s_valid & e_s_ready;
  assign push      = in_fire & (in_cnt == ICW'(N - 1));

  // Output side: the FIFO head owns the engine's result stream; nothing is taken while empty.
  assign fifo_ne   = (count != '0);
  assign head      = tag_mem[rd_ptr];
  assign e_m_ready = fifo_ne & (head ? m_ready1 : m_ready0);
  assign m_valid0  = fifo_ne & ~head & e_m_valid;
  assign m_valid1  = fifo_ne &  head & e_m_valid;
  assign data_out  = e_data_out;
  assign out_fire  = e_m_valid & e_m_ready;
  assign pop       = out_fire & (out_cnt == OCW'(M - 1));

  assign req_any    = s_valid0 | s_valid1;
  assign next_grant = (s_valid0 & s_valid1) ? ~last_grant : s_valid1;
  assign busy       = (state == PASS) | fifo_ne;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      in_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_any && (count < CW'(DEPTH))) begin
            grant <= next_grant;
            state <= PASS;
          end
        end
        PASS: begin
          if (in_fire) begin
            if (push) begin
              in_cnt     <= '0;
              last_grant <= grant;
              state      <= IDLE;
            end else begin
              in_cnt <= in_cnt + ICW'(1);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_mem <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      out_cnt <= '0;
    end else begin
      if (push) begin
        tag_mem[wr_ptr] <= grant;
        wr_ptr          <= ptr_next(wr_ptr);
      end
      if (out_fire) begin
        out_cnt <= pop ? '0 : out_cnt + OCW'(1);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_engine_arbiter.sv
// tb/tb_layer_engine_arbiter.sv - randomized bench with vector-level reference model
// Requester id rides in the top data bit so the owner of every word is self-evident.
module tb_layer_engine_arbiter;

  localparam int M = 8;
  localparam int N = 8;
  localparam int T = 12;
  localparam int DEPTH = 2;
  localparam logic [31:0] NONE = 32'hDEAD_BEEF;

  logic         clk = 1'b0;
  logic         reset;
  logic         s_valid0, s_ready0, s_valid1, s_ready1;
  logic [T-1:0] data_in0, data_in1;
  logic         m_valid0, m_ready0, m_valid1, m_ready1;
  logic [T-1:0] data_out;
  logic         e_s_valid, e_s_ready, e_m_valid, e_m_ready;
  logic [T-1:0] e_data_in, e_data_out;
  logic         busy;

  always #5 clk = ~clk;

  layer_engine_arbiter #(.M(M), .N(N), .T(T), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .s_valid0(s_valid0), .s_ready0(s_ready0), .data_in0(data_in0),
    .s_valid1(s_valid1), .s_ready1(s_ready1), .data_in1(data_in1),
    .m_valid0(m_valid0), .m_ready0(m_ready0),
    .m_valid1(m_valid1), .m_ready1(m_ready1), .data_out(data_out),
    .e_s_valid(e_s_valid), .e_s_ready(e_s_ready), .e_data_in(e_data_in),
    .e_m_valid(e_m_valid), .e_m_ready(e_m_ready), .e_data_out(e_data_out),
    .busy(busy)
  );

  int checks = 0;
  int passes = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic [T-1:0] pq0[$], pq1[$], exp0[$], exp1[$], eng_in[$], eng_out[$];
  int in_words, out_words, completed, drained, forced_next, owner, gap0, gap1;
  int pct_esr, pct_emv, pct_mr0, pct_mr1, gap_max;
  bit hold0, esr_toggle;
  int s1_high, m0_fires, m1_fires, e_in_fires;
  logic s0f, s1f, ef, of, m0f, m1f;
  bit done0, done1;

  function automatic logic [T-1:0] res_word(input logic [T-1:0] w, input int j);
    logic [T-2:0] k;
    k = (T-1)'(j * 37 + 5);
    return {w[T-1], w[T-2:0] ^ k};
  endfunction

  function automatic bit roll(input int pct);
    return int'($urandom_range(0, 99)) < pct;
  endfunction

  task automatic add_vector(input int r);
    logic [T-1:0] v [N];
    logic [T-1:0] rb;
    rb = T'(r);
    for (int j = 0; j < N; j++) begin
      v[j] = {rb[0], (T-1)'($urandom)};
      if (r == 0) pq0.push_back(v[j]); else pq1.push_back(v[j]);
    end
    for (int j = 0; j < M; j++) begin
      if (r == 0) exp0.push_back(res_word(v[j % N], j));
      else        exp1.push_back(res_word(v[j % N], j));
    end
  endtask

  task automatic clear_model();
    pq0.delete(); pq1.delete(); exp0.delete(); exp1.delete();
    eng_in.delete(); eng_out.delete();
    in_words = 0; out_words = 0; completed = 0; drained = 0;
    forced_next = -1; owner = 0; gap0 = 0; gap1 = 0;
    {s0f, s1f, ef, of, m0f, m1f} = '0;
    done0 = 0; done1 = 0;
    s_valid0 = 0; s_valid1 = 0; data_in0 = '0; data_in1 = '0;
    e_s_ready = 0; e_m_valid = 0; e_data_out = '0; m_ready0 = 0; m_ready1 = 0;
  endtask

  task automatic sample();
    s0f = s_valid0 & s_ready0;  s1f = s_valid1 & s_ready1;
    ef  = e_s_valid & e_s_ready; of  = e_m_valid & e_m_ready;
    m0f = m_valid0 & m_ready0;  m1f = m_valid1 & m_ready1;
    done0 = 0; done1 = 0;
    if ((in_words > 0) || (completed != drained)) check_eq("busy_outstanding", busy, 1);
    if (m_valid0 | m_valid1) check_eq("m_valid_onehot", m_valid0 & m_valid1, 0);
    s1_high += int'(s_ready1); m0_fires += int'(m0f); m1_fires += int'(m1f); e_in_fires += int'(ef);
    if (ef) begin
      if (in_words == 0) begin
        owner = int'(e_data_in[T-1]);
        if (forced_next >= 0) check_eq("grant_order", owner, forced_next);
        check_eq("grant_room", (completed - drained) < DEPTH, 1);
      end
      check_eq("s_handshake", {s1f, s0f}, (owner == 1) ? 2'b10 : 2'b01);
      if (owner == 0) begin
        check_eq("in_data0", e_data_in, (pq0.size() > 0) ? 32'(pq0[0]) : NONE);
        if (pq0.size() > 0) void'(pq0.pop_front());
      end else begin
        check_eq("in_data1", e_data_in, (pq1.size() > 0) ? 32'(pq1[0]) : NONE);
        if (pq1.size() > 0) void'(pq1.pop_front());
      end
      eng_in.push_back(e_data_in);
      if (eng_in.size() == N) begin
        for (int j = 0; j < M; j++) eng_out.push_back(res_word(eng_in[j % N], j));
        eng_in.delete();
      end
      in_words++;
      if (in_words == N) begin
        in_words = 0;
        completed++;
        forced_next = ((owner == 1) ? s_valid0 : s_valid1) ? 1 - owner : -1;
        if (owner == 1) done1 = 1; else done0 = 1;
      end
    end else if (s0f | s1f) begin
      check_eq("s_without_engine", {s1f, s0f}, 0);
    end
    if (of | m0f | m1f) check_eq("route_handshake", {of, m0f | m1f}, 2'b11);
    if (m0f) begin
      check_eq("out_data0", data_out, (exp0.size() > 0) ? 32'(exp0[0]) : NONE);
      if (exp0.size() > 0) void'(exp0.pop_front());
    end
    if (m1f) begin
      check_eq("out_data1", data_out, (exp1.size() > 0) ? 32'(exp1[0]) : NONE);
      if (exp1.size() > 0) void'(exp1.pop_front());
    end
    if (of) begin
      out_words++;
      if (out_words == M) begin out_words = 0; drained++; end
    end
  endtask

  task automatic drive();
    if (of && eng_out.size() > 0) void'(eng_out.pop_front());
    if (done0) gap0 = int'($urandom_range(0, gap_max)); else if (gap0 > 0) gap0--;
    if (done1) gap1 = int'($urandom_range(0, gap_max)); else if (gap1 > 0) gap1--;
    s_valid0 = (pq0.size() > 0) && (gap0 == 0);
    s_valid1 = (pq1.size() > 0) && (gap1 == 0);
    data_in0 = (pq0.size() > 0) ? pq0[0] : '0;
    data_in1 = (pq1.size() > 0) ? pq1[0] : '0;
    if (!(e_m_valid && !of)) e_m_valid = (eng_out.size() > 0) && roll(pct_emv);
    e_data_out = e_m_valid ? eng_out[0] : T'($urandom);
    e_s_ready  = esr_toggle ? ~e_s_ready : roll(pct_esr);
    m_ready0   = hold0 ? 1'b0 : roll(pct_mr0);
    m_ready1   = roll(pct_mr1);
  endtask

  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic apply_reset();
    reset = 1;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
  endtask

  task automatic drain(input string tag);
    int cyc;
    cyc = 0;
    while ((pq0.size() + pq1.size() + exp0.size() + exp1.size()) != 0 && cyc < 4000) begin
      step();
      cyc++;
    end
    check_eq({tag, "_drained"}, pq0.size() + pq1.size() + exp0.size() + exp1.size(), 0);
    step();
    step();
    check_eq({tag, "_idle"}, busy, 0);
  endtask

  task automatic run_until_completed(input int target, input string tag);
    int cyc;
    cyc = 0;
    while (completed < target && cyc < 200) begin step(); cyc++; end
    check_eq(tag, completed, target);
  endtask

  task automatic all_ready();
    pct_esr = 100; pct_emv = 100; pct_mr0 = 100; pct_mr1 = 100;
  endtask

  initial begin
    reset = 1;
    clear_model();
    all_ready();
    hold0 = 0; esr_toggle = 0; gap_max = 0;
    s1_high = 0; m0_fires = 0; m1_fires = 0; e_in_fires = 0;
    #1;
    check_eq("reset_outputs", {s_ready0, s_ready1, m_valid0, m_valid1, e_s_valid, e_m_ready, busy}, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 0;

    // requester 0 alone
    add_vector(0);
    forced_next = 0;
    drain("req0_only");
    check_eq("a_s_ready1_never", s1_high, 0);
    check_eq("a_m_valid1_fires", m1_fires, 0);
    check_eq("a_m_valid0_fires", m0_fires, M);

    // both valid right after reset: 0 first, then 1
    apply_reset();
    add_vector(0);
    add_vector(1);
    forced_next = 0;
    e_in_fires = 0;
    drain("both_after_reset");
    check_eq("b_words", e_in_fires, 2 * N);

    // continuous requests from both must alternate
    pct_esr = 70; pct_emv = 70; pct_mr0 = 60; pct_mr1 = 60; gap_max = 0;
    for (int i = 0; i < 4; i++) begin add_vector(0); add_vector(1); end
    drain("alternate");

    // randomized traffic
    gap_max = 6;
    for (int r = 0; r < 6; r++) begin
      pct_esr = int'($urandom_range(20, 100)); pct_emv = int'($urandom_range(20, 100));
      pct_mr0 = int'($urandom_range(10, 100)); pct_mr1 = int'($urandom_range(10, 100));
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 1) == 1) add_vector(0);
        if ($urandom_range(0, 1) == 1) add_vector(1);
      end
      drain("random");
    end

    // tag FIFO full: third request waits for A's results to drain
    apply_reset();
    all_ready();
    gap_max = 0;
    hold0 = 1;
    add_vector(0);
    run_until_completed(1, "d_vector_a");
    add_vector(1);
    run_until_completed(2, "d_vector_b");
    add_vector(0);
    e_in_fires = 0; m1_fires = 0;
    repeat (40) step();
    check_eq("d_no_third_grant", e_in_fires, 0);
    check_eq("d_b_results_wait", m1_fires, 0);
    check_eq("d_busy_full", busy, 1);
    hold0 = 0;
    drain("depth");
    check_eq("d_b_to_port1", m1_fires, M);
    check_eq("d_third_words", e_in_fires, N);

    // engine ready toggling every cycle
    esr_toggle = 1;
    e_in_fires = 0;
    add_vector(0);
    drain("toggle");
    check_eq("e_words", e_in_fires, N);
    esr_toggle = 0;

    // reset in the middle of an input vector
    all_ready();
    add_vector(0);
    begin
      int cyc;
      cyc = 0;
      while (in_words != 3 && cyc < 100) begin step(); cyc++; end
    end
    check_eq("f_reach_word3", in_words, 3);
    reset = 1;
    #1;
    check_eq("f_reset_outputs", {s_ready0, s_ready1, m_valid0, m_valid1, e_s_valid, e_m_ready, busy}, 0);
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    add_vector(0);
    forced_next = 0;
    e_in_fires = 0;
    drain("after_reset");
    check_eq("f_words", e_in_fires, N);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
